// File: rtl/rotl_iterative.sv
// Multi-cycle left cyclic rotator: accepts a word and amount, rotates left by
// up to STEP bits per clock, and returns the result over a valid/ready handshake.
module rotl_iterative #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  parameter int unsigned AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [AW:0] STEP_AMT  = (AW+1)'(STEP);
  localparam logic [AW:0] WIDTH_AMT = (AW+1)'(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AW:0]      rem_q, rem_d;
  logic             in_ready_q, out_valid_q;

  logic [AW:0]      step_c;
  logic [AW:0]      rshamt_c;
  logic [AW:0]      rem_next_c;
  logic [WIDTH-1:0] rot_c;

  // One rotate step of min(STEP, remaining); a full-width step degenerates to identity.
  always_comb begin
    step_c     = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
    rshamt_c   = WIDTH_AMT - step_c;
    rem_next_c = rem_q - step_c;
    rot_c      = (data_q << step_c) | (data_q >> rshamt_c);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d  = in_data;
          rem_d   = {1'b0, in_amount};
          state_d = (in_amount == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        data_d = rot_c;
        rem_d  = rem_next_c;
        if (rem_next_c == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      rem_q       <= rem_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_rotl_iterative.sv
// Bench for rotl_iterative: STEP=1 and STEP=4 instances checked against a
// bit-placement rotate model with directed and random requests.
module tb_rotl_iterative;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_data   [2];
  logic [4:0]  in_amount [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_data  [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rotl_iterative #(.WIDTH(32), .STEP(1)) u_step1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_amount(in_amount[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0])
  );

  rotl_iterative #(.WIDTH(32), .STEP(4)) u_step4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_amount(in_amount[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1])
  );

  // Reference: bit i of x lands at position (i+n) mod 32.
  function automatic logic [31:0] ref_rotl(input logic [31:0] x, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[(i + n) % 32] = x[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input int u, input logic [31:0] x, input int n, input int stall,
                     input bit hold, output logic [31:0] res);
    int step;
    int k;
    int cyc;
    bit busy_ok;
    step = (u == 0) ? 1 : 4;
    k = (n + step - 1) / step;
    @(negedge clk);
    chk("pre_ready", 32'(in_ready[u]), 32'd1);
    in_valid[u]  = 1'b1;
    in_data[u]   = x;
    in_amount[u] = 5'(n);
    out_ready[u] = 1'b0;
    @(posedge clk);
    #1;
    if (hold) begin
      in_data[u]   = $urandom;
      in_amount[u] = 5'($urandom);
    end else begin
      in_valid[u] = 1'b0;
    end
    @(negedge clk);
    cyc = 0;
    busy_ok = 1'b1;
    while (out_valid[u] !== 1'b1 && cyc < 100) begin
      if (in_ready[u] !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk("busy_ready_low", 32'(busy_ok), 32'd1);
    chk("latency", 32'(cyc), 32'(k));
    chk("result", out_data[u], ref_rotl(x, n));
    chk("ready_in_done", 32'(in_ready[u]), 32'd0);
    res = out_data[u];
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid[u]), 32'd1);
      chk("stall_data", out_data[u], res);
    end
    out_ready[u] = 1'b1;
    @(negedge clk);
    chk("valid_drop", 32'(out_valid[u]), 32'd0);
    chk("ready_rise", 32'(in_ready[u]), 32'd1);
    in_valid[u]  = 1'b0;
    out_ready[u] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] res;
    bit seen;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0; in_data[u] = '0; in_amount[u] = '0; out_ready[u] = 1'b0;
    end

    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_data", out_data[0], 32'h0);
    chk("rst_ready", 32'(in_ready[0]), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready_still_low", 32'(in_ready[0]), 32'd0);

    // Directed STEP=1 cases
    run(0, 32'h8000_0001, 1, 0, 1'b0, res);
    chk("rotl1_const", res, 32'h0000_0003);
    run(0, 32'hDEAD_BEEF, 0, 0, 1'b0, res);
    chk("rotl0_const", res, 32'hDEAD_BEEF);
    run(0, 32'h0000_0001, 31, 0, 1'b1, res);
    chk("rotl31_const", res, 32'h8000_0000);

    // Reset pulse mid-stream, then ready returns one cycle after release
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("pulse_valid", 32'(out_valid[0]), 32'd0);
    chk("pulse_data", out_data[0], 32'h0);
    chk("pulse_ready", 32'(in_ready[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("pulse_ready_back", 32'(in_ready[0]), 32'd1);
    chk("pulse_data_after", out_data[0], 32'h0);

    // Directed STEP=4 cases
    run(1, 32'h1234_5678, 6, 0, 1'b0, res);
    chk("s4_rotl6_const", res, 32'h8D15_9E04);
    run(1, 32'h1234_5678, 8, 0, 1'b0, res);
    chk("s4_rotl8_const", res, 32'h3456_7812);

    // Backpressure: 10 stalled cycles in DONE
    run(0, 32'hA5A5_0F0F, 13, 10, 1'b0, res);

    // Abort during SHIFT: no result pulse, next request fine
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = 32'hCAFE_F00D; in_amount[0] = 5'd20;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(out_valid[0]), 32'd0);
    chk("abort_data", out_data[0], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    out_ready[0] = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (out_valid[0] === 1'b1) seen = 1'b1;
    end
    out_ready[0] = 1'b0;
    chk("abort_no_pulse", 32'(seen), 32'd0);
    run(0, 32'hCAFE_F00D, 20, 1, 1'b0, res);

    // Random requests on both step sizes
    for (int it = 0; it < 20; it++) begin
      for (int u = 0; u < 2; u++) begin
        run(u, $urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
            bit'($urandom_range(0, 1)), res);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rotl_iterative.md
# rotl_iterative

Multi-cycle left cyclic rotator for the SHA-256 datapath and its bench. It is the opposite-direction companion to the combinational right-rotate primitive. It accepts a word and a runtime rotate amount over a valid/ready handshake and rotates left by up to STEP bits per clock. It returns the result over a second valid/ready handshake, giving the hash core and test harness a cheap, area-light ROTL whose amount is chosen at run time.

## Interface
- WIDTH, 32: data word width; power of 2, ≥ 2.
- STEP, 1: maximum bits rotated per clock; power of 2, 1 ≤ STEP ≤ WIDTH.
- AW, $clog2(WIDTH): width of the amount field; derived, not to be overridden.

- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_amount present.
- in_ready  output  1  block can accept a request.
- in_data  input  WIDTH  word to rotate.
- in_amount  input  AW  left-rotate amount, 0..WIDTH-1.
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  consumer takes the result.
- out_data  output  WIDTH  rotated word.

## Operation
- States: IDLE, SHIFT, DONE.
- Registers:
  - data_r (WIDTH bits), drives out_data directly.
  - rem_r (AW+1 bits), the remaining rotate count.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: data_r←in_data, rem_r←in_amount.
  - Next state is DONE if in_amount==0, else SHIFT.
- SHIFT:
  - in_ready=0, out_valid=0.
  - Each clock, s=min(STEP, rem_r); data_r←{data_r[WIDTH-1-s:0], data_r[WIDTH-1:WIDTH-s]}; rem_r←rem_r−s.
  - When rem_r−s==0, go to DONE.
- DONE:
  - out_valid=1, in_ready=0. data_r and rem_r hold.
  - On out_valid&&out_ready, go to IDLE.
- Arithmetic and width rules:
  - The amount is interpreted modulo WIDTH by construction, since AW bits cannot exceed WIDTH-1.
  - No sign handling.
  - Result equals (x<<n)|(x>>(WIDTH−n)) for n≠0, and x for n=0.
- No request overlap: a new request is accepted only in IDLE, never in the DONE→IDLE cycle.
- in_data and in_amount are sampled only on the accept edge. Changes afterwards are ignored.

## Timing
- Reset values (asynchronous, take effect immediately, no clock needed):
  - state=IDLE, data_r=0 (out_data=0), rem_r=0, out_valid=0.
  - in_ready is forced 0 while rst is high and returns to 1 on the first cycle after deassertion.
- Latency:
  - With accept at edge E0, out_valid rises after edge E(k), where k=ceil(n/STEP).
  - n=0 gives out_valid in the cycle immediately after E0.
  - STEP=1, n=31 gives 31 SHIFT clocks.
- Throughput: one result per k+2 clocks with out_ready tied high (accept, k shifts, DONE handshake).
- Backpressure: while out_ready=0 in DONE, out_valid and out_data hold stable indefinitely.
- out_data is only meaningful while out_valid=1. During SHIFT it shows intermediate values.
- Reset mid-SHIFT or mid-DONE aborts the operation and discards the result. No out_valid pulse is generated.
- in_valid held high while busy: no effect. The request is re-sampled only once back in IDLE.
- in_valid and out_ready high together in DONE: the result completes, but the new request is not accepted until the following IDLE cycle.

## Test plan
- STEP=1, reset pulse mid-stream: during and after reset out_valid=0 and out_data=0x00000000. in_ready=0 during reset and 1 one cycle after release.
- STEP=1:
  - in_data=0x80000001, amount=1: out_data=0x00000003, out_valid exactly 1 cycle after the accept edge.
  - amount=0 with data 0xDEADBEEF: out_data=0xDEADBEEF, out_valid in the cycle after accept.
- STEP=1, in_data=0x00000001, amount=31: out_data=0x80000000 after 31 SHIFT cycles. in_ready stays 0 throughout.
- STEP=4:
  - 0x12345678 rotl 6: out_data=0x8D159E04 after 2 SHIFT cycles (4 then 2).
  - rotl 8: out_data=0x34567812 after 2 cycles.
- Backpressure and abort:
  - Hold out_ready=0 for 10 cycles in DONE: out_valid and out_data stay stable. Release, then out_valid drops and in_ready rises next cycle.
  - Assert rst during SHIFT: no output pulse, and the next request completes correctly.
